// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage 16-bit CPU: load-use, branch flush, data-memory wait/timeout, EX forwarding.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_count / lu_count outputs.
module hazard_control_unit #(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wb_en,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wb_en,
  input  logic              mem_access,
  input  logic              mem_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wb_en,
  output logic              stall_pc,
  output logic              stall_fd,
  output logic              stall_de,
  output logic              stall_em,
  output logic              bubble_de,
  output logic              bubble_mw,
  output logic              flush_fd,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mem_error
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  lu_count
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] ABORT_MARK = CW'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic           abort_cyc;
  logic           mem_stall;
  logic           br_flush;
  logic           ld_hit;
  logic           lu_stall;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;

  // A non-zero wait_cnt while in RUN marks the single abort cycle after a timeout.
  assign abort_cyc = (state == RUN) && (wait_cnt != '0);

  always_comb begin
    ld_hit    = ex_mem_read && ex_wb_en && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    mem_stall = mem_access && !mem_ready && !abort_cyc;
    br_flush  = ex_branch_taken && !mem_stall;
    lu_stall  = ld_hit && !ex_branch_taken && !mem_stall && !abort_cyc;
  end

  always_comb begin
    fwd_a = 2'b00;
    if (mem_wb_en && (mem_rd == ex_rs1) && (mem_rd != '0))
      fwd_a = 2'b01;
    else if (wb_wb_en && (wb_rd == ex_rs1) && (wb_rd != '0))
      fwd_a = 2'b10;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_wb_en && (mem_rd == ex_rs2) && (mem_rd != '0))
      fwd_b = 2'b01;
    else if (wb_wb_en && (wb_rd == ex_rs2) && (wb_rd != '0))
      fwd_b = 2'b10;
  end

  // Every control output is held low while reset is asserted.
  assign stall_pc  = rst_n && (mem_stall || lu_stall);
  assign stall_fd  = rst_n && (mem_stall || lu_stall);
  assign stall_de  = rst_n && mem_stall;
  assign stall_em  = rst_n && mem_stall;
  assign bubble_de = rst_n && (br_flush || lu_stall);
  assign bubble_mw = rst_n && (mem_stall || abort_cyc);
  assign flush_fd  = rst_n && br_flush;
  assign fwd_a_sel = rst_n ? fwd_a : 2'b00;
  assign fwd_b_sel = rst_n ? fwd_b : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (abort_cyc) begin
            wait_cnt <= '0;
          end else if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TO_LAST) begin
            mem_error <= 1'b1;
            state     <= RUN;
            wait_cnt  <= ABORT_MARK;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      lu_count     <= '0;
    end else begin
      if (stall_pc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (br_flush && (flush_count != '1))  flush_count  <= flush_count + CNT_W'(1);
      if (lu_stall && (lu_count != '1))     lu_count     <= lu_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_control_unit;

  localparam int AW = 4;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_wb_en, ex_mem_read, ex_branch_taken;
  logic          mem_wb_en, mem_access, mem_ready, wb_wb_en;
  logic          stall_pc, stall_fd, stall_de, stall_em, bubble_de, bubble_mw, flush_fd, mem_error;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [15:0]   stall_cycles, flush_count, lu_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_control_unit #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .mem_access(mem_access), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_wb_en(wb_wb_en),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_de(stall_de), .stall_em(stall_em),
    .bubble_de(bubble_de), .bubble_mw(bubble_mw), .flush_fd(flush_fd),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_error(mem_error)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .lu_count(lu_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [11:0] dut_vec = {stall_pc, stall_fd, stall_de, stall_em, bubble_de, bubble_mw,
                         flush_fd, fwd_a_sel, fwd_b_sel, mem_error};

  // Model state: length of the current continuous memory stall, pending abort cycle, sticky error.
  int m_run;
  bit m_abort;
  bit m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 0;
      m_abort <= 1'b0;
      m_err   <= 1'b0;
    end else if (m_abort) begin
      m_abort <= 1'b0;
      m_run   <= 0;
    end else if (mem_access && !mem_ready) begin
      if (m_run + 1 == TO) begin
        m_err   <= 1'b1;
        m_abort <= 1'b1;
        m_run   <= 0;
      end else begin
        m_run <= m_run + 1;
      end
    end else begin
      m_run <= 0;
    end
  end

  function automatic logic [1:0] fwd_ref(input int rs, input int mrd, input bit men, input int wrd, input bit wen);
    if (men && mrd == rs && rs != 0) return 2'b01;
    if (wen && wrd == rs && rs != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] exp_vec();
    bit hit, ms, br, lu;
    if (!rst_n) return 12'd0;
    hit = ex_mem_read && ex_wb_en && ex_rd != 0 &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    ms = !m_abort && mem_access && !mem_ready;
    br = !ms && ex_branch_taken;
    lu = !ms && !m_abort && !ex_branch_taken && hit;
    return {ms | lu, ms | lu, ms, ms, br | lu, ms | m_abort, br,
            fwd_ref(int'(ex_rs1), int'(mem_rd), mem_wb_en, int'(wb_rd), wb_wb_en),
            fwd_ref(int'(ex_rs2), int'(mem_rd), mem_wb_en, int'(wb_rd), wb_wb_en), m_err};
  endfunction

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_wb_en = 1'b0; ex_mem_read = 1'b0; ex_rs1 = '0; ex_rs2 = '0;
    ex_branch_taken = 1'b0; mem_rd = '0; mem_wb_en = 1'b0; mem_access = 1'b0;
    mem_ready = 1'b0; wb_rd = '0; wb_wb_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (dut_vec !== 12'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 000", dut_vec); end
`ifdef HAZARD_PERF_EN
    n_tests++;
    if ({stall_cycles, flush_count, lu_count} !== 48'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h/%h expected 0", stall_cycles, flush_count, lu_count);
    end
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_tests++;
    if (dut_vec !== 12'd0) begin n_fail++; $display("FAIL idle_after_reset: got %h expected 000", dut_vec); end
    tick();
  endtask

  task automatic test_forwarding();
    idle();
    ex_rs1 = 4'd3; ex_rs2 = 4'd3; mem_rd = 4'd3; mem_wb_en = 1'b1; wb_rd = 4'd3; wb_wb_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL fwd_a_mem: got %b expected 01", fwd_a_sel); end
    n_tests++;
    if (fwd_b_sel !== 2'b01) begin n_fail++; $display("FAIL fwd_b_mem: got %b expected 01", fwd_b_sel); end
    tick();
    mem_wb_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL fwd_a_wb: got %b expected 10", fwd_a_sel); end
    tick();
    ex_rs1 = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0; mem_wb_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL fwd_a_r0: got %b expected 00", fwd_a_sel); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5; id_use_rs2 = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({stall_pc, stall_fd, bubble_de, stall_de, flush_fd} !== 5'b11100) begin
      n_fail++; $display("FAIL load_use_stall: got %b expected 11100", {stall_pc, stall_fd, bubble_de, stall_de, flush_fd});
    end
    tick();
    // Load moves to MEM, EX holds the bubble, the consumer stays in ID.
    ex_mem_read = 1'b0; ex_wb_en = 1'b0; ex_rd = 4'd0; mem_rd = 4'd5; mem_wb_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({stall_pc, bubble_de} !== 2'b00) begin
      n_fail++; $display("FAIL load_use_one_cycle: got %b expected 00", {stall_pc, bubble_de});
    end
    tick();
    mem_rd = 4'd0; mem_wb_en = 1'b0; wb_rd = 4'd5; wb_wb_en = 1'b1; ex_rs2 = 4'd5;
    @(negedge clk);
    n_tests++;
    if (fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL load_use_fwd_wb: got %b expected 10", fwd_b_sel); end
    tick();
    idle();
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5; id_use_rs2 = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({stall_pc, stall_fd, bubble_de} !== 3'b000) begin
      n_fail++; $display("FAIL load_use_unused_rs2: got %b expected 000", {stall_pc, stall_fd, bubble_de});
    end
    tick();
  endtask

  task automatic test_branch_priority();
    idle();
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd7; id_rs1 = 4'd7; id_use_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({flush_fd, bubble_de, stall_pc, stall_fd} !== 4'b1100) begin
      n_fail++; $display("FAIL branch_over_load_use: got %b expected 1100", {flush_fd, bubble_de, stall_pc, stall_fd});
    end
    tick();
    mem_access = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({flush_fd, bubble_de, stall_pc} !== 3'b001) begin
      n_fail++; $display("FAIL branch_held_by_mem: got %b expected 001", {flush_fd, bubble_de, stall_pc});
    end
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({flush_fd, bubble_de, stall_pc} !== 3'b110) begin
      n_fail++; $display("FAIL branch_on_release: got %b expected 110", {flush_fd, bubble_de, stall_pc});
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_mem_wait();
    int stalls = 0;
    idle();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stall_em === 1'b1 && bubble_mw === 1'b1 && stall_pc === 1'b1) stalls++;
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({stall_em, bubble_mw, stall_pc} !== 3'b000) begin
      n_fail++; $display("FAIL mem_wait_release: got %b expected 000", {stall_em, bubble_mw, stall_pc});
    end
    n_tests++;
    if (stalls != 3) begin n_fail++; $display("FAIL mem_wait_len: got %0d expected 3", stalls); end
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({stall_em, mem_error} !== 2'b00) begin
      n_fail++; $display("FAIL mem_zero_wait: got %b expected 00", {stall_em, mem_error});
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    bit done = 1'b0;
    idle();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall_em === 1'b1) begin
        stalls++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL timeout_bound: stall never dropped within 20 cycles"); end
    n_tests++;
    if (stalls != TO) begin n_fail++; $display("FAIL timeout_len: got %0d expected %0d", stalls, TO); end
    n_tests++;
    if ({mem_error, bubble_mw, stall_pc, stall_de} !== 4'b1100) begin
      n_fail++; $display("FAIL timeout_abort: got %b expected 1100", {mem_error, bubble_mw, stall_pc, stall_de});
    end
    tick();
    idle();
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if (mem_error !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", mem_error); end
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_rd = AW'($urandom_range(0, 3)); ex_wb_en = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_rd = AW'($urandom_range(0, 3)); mem_wb_en = 1'($urandom);
      mem_access = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      wb_rd = AW'($urandom_range(0, 3)); wb_wb_en = 1'($urandom);
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        if (errs < 5) $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec, exp_vec());
        errs++;
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle();
    mem_access = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_vec !== 12'd0) begin n_fail++; $display("FAIL reset_mid_wait: got %h expected 000", dut_vec); end
    tick();
    idle();
    rst_n = 1'b1;
    mem_access = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({stall_em, bubble_mw, mem_error} !== 3'b000) begin
      n_fail++; $display("FAIL run_after_reset: got %b expected 000", {stall_em, bubble_mw, mem_error});
    end
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({stall_em, bubble_mw} !== 2'b11) begin
      n_fail++; $display("FAIL new_wait_after_reset: got %b expected 11", {stall_em, bubble_mw});
    end
    tick();
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
